clock_period_meter: RTL

- Measures a slow divided clock (or any square wave) in units of the fast system clock.
- Reports period and high time per cycle of the input.
- Sits downstream of the clock divider, on the receiving end of its clk_out, for self-check and for status readout in the counter design.
- Input is treated as asynchronous and synchronised internally. No logic is clocked by the measured signal.

---
 rtl/clock_period_meter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles.
// sig_in is synchronised internally; no logic is clocked by the measured signal.
module clock_period_meter #(
    parameter int               CNT_W       = 28,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(16000000),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = TIMEOUT - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;
    logic                   sig_s;
    logic                   rise;
    logic                   fall;
    logic                   at_limit;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       hi_cap_reg;

    // Synchroniser chain plus one flop for edge detection; the latency is
    // the same for both edges, so it cancels out of every measurement.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            s_d_reg  <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sig_s    = sync_reg[SYNC_STAGES-1];
    assign rise     = sig_s & ~s_d_reg;
    assign fall     = ~sig_s & s_d_reg;
    // >= rather than == so a fall accepted right at the limit still times out next cycle
    assign at_limit = (cnt_reg >= LIMIT);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hi_cap_reg <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!meas_en) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                timeout   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                busy <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        state_reg <= ARM;
                        cnt_reg   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            state_reg <= HIGH;
                            cnt_reg   <= CNT_ONE;
                        end else if (at_limit) begin
                            timeout <= 1'b1;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state_reg  <= LOW;
                            hi_cap_reg <= cnt_reg;
                            cnt_reg    <= cnt_reg + 1'b1;
                        end else if (at_limit) begin
                            timeout   <= 1'b1;
                            state_reg <= ARM;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            // Publish and start the next period on the same cycle.
                            period_out <= cnt_reg;
                            high_out   <= hi_cap_reg;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            state_reg  <= HIGH;
                            cnt_reg    <= CNT_ONE;
                        end else if (at_limit) begin
                            timeout   <= 1'b1;
                            state_reg <= ARM;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
